// File: rtl/time_set_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// time_set_ctrl_pkg
// Shared definitions for the time-setting controller: FSM state encoding,
// the BCD time record, the 12:00 AM default constants, the field ranges used
// by the BCD wrap counters and small validity helpers for loading live time.
// -----------------------------------------------------------------------------
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_EDIT_HOUR = 2'd1,
    ST_EDIT_MIN  = 2'd2,
    ST_COMMIT    = 2'd3
  } state_e;

  // 12-hour BCD time without seconds; field widths follow the RTC reader.
  typedef struct packed {
    logic       hour_10;
    logic [3:0] hour_1;
    logic [2:0] min_10;
    logic [3:0] min_1;
    logic       pm;
  } bcd_time_t;

  // 12:00 AM, the value an unset or corrupt clock falls back to.
  localparam logic       DEF_HOUR_10 = 1'b1;
  localparam logic [3:0] DEF_HOUR_1  = 4'd2;
  localparam logic [2:0] DEF_MIN_10  = 3'd0;
  localparam logic [3:0] DEF_MIN_1   = 4'd0;
  localparam logic       DEF_PM      = 1'b0;

  localparam bcd_time_t DEF_TIME = '{
    hour_10: DEF_HOUR_10,
    hour_1:  DEF_HOUR_1,
    min_10:  DEF_MIN_10,
    min_1:   DEF_MIN_1,
    pm:      DEF_PM
  };

  // Field ranges as two-digit BCD.
  localparam logic [7:0] HOUR_MIN_BCD = 8'h01;
  localparam logic [7:0] HOUR_MAX_BCD = 8'h12;
  localparam logic [7:0] MIN_MIN_BCD  = 8'h00;
  localparam logic [7:0] MIN_MAX_BCD  = 8'h59;

  function automatic logic is_edit(input state_e s);
    return (s == ST_EDIT_HOUR) || (s == ST_EDIT_MIN);
  endfunction

  // 01..09 or 10..12; anything else (including a non-BCD nibble) is invalid.
  function automatic logic hour_valid(input logic h10, input logic [3:0] h1);
    return h10 ? (h1 <= 4'd2) : ((h1 != 4'd0) && (h1 <= 4'd9));
  endfunction

  function automatic logic min_valid(input logic [2:0] m10, input logic [3:0] m1);
    return (m10 <= 3'd5) && (m1 <= 4'd9);
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// -----------------------------------------------------------------------------
// time_set_ctrl_if
// Bundles everything the controller exchanges with the RTC reader and the
// display stage.
//   master : the controller (reads live time / flags, drives commit + display)
//   slave  : the RTC reader / display side
//   new_time, need_config   strobe and "clock unset" flag from the RTC reader
//   sec_*, min_*, hour_*, pm live 12-hour BCD time
//   set_time, set_*         one-cycle commit strobe and the edited time
//   disp_*                  time to show
//   blank_hour, blank_min   blink blanking per field
//   editing                 high while a field is being edited
// -----------------------------------------------------------------------------
interface time_set_ctrl_if;

  logic       new_time;
  logic       need_config;
  logic [3:0] sec_1;
  logic [2:0] sec_10;
  logic [3:0] min_1;
  logic [2:0] min_10;
  logic [3:0] hour_1;
  logic       hour_10;
  logic       pm;

  logic       set_time;
  logic [3:0] set_min_1;
  logic [2:0] set_min_10;
  logic [3:0] set_hour_1;
  logic       set_hour_10;
  logic       set_pm;

  logic [3:0] disp_min_1;
  logic [2:0] disp_min_10;
  logic [3:0] disp_hour_1;
  logic       disp_hour_10;
  logic       disp_pm;
  logic       blank_hour;
  logic       blank_min;
  logic       editing;

  modport master (
    input  new_time, need_config, sec_1, sec_10, min_1, min_10, hour_1, hour_10, pm,
    output set_time, set_min_1, set_min_10, set_hour_1, set_hour_10, set_pm,
    output disp_min_1, disp_min_10, disp_hour_1, disp_hour_10, disp_pm,
    output blank_hour, blank_min, editing
  );

  modport slave (
    output new_time, need_config, sec_1, sec_10, min_1, min_10, hour_1, hour_10, pm,
    input  set_time, set_min_1, set_min_10, set_hour_1, set_hour_10, set_pm,
    input  disp_min_1, disp_min_10, disp_hour_1, disp_hour_10, disp_pm,
    input  blank_hour, blank_min, editing
  );

endinterface

// File: rtl/time_set_ctrl_bcd_wrap_counter.sv
// -----------------------------------------------------------------------------
// bcd_wrap_counter
// Next-value logic for a two-digit BCD field that steps by one and wraps from
// MAX_BCD back to MIN_BCD. The tens digit width is configurable so the same
// block serves the 1-bit hour tens and the 3-bit minute tens.
//   tens_i, ones_i : current value
//   tens_o, ones_o : value after one increment
// -----------------------------------------------------------------------------
module bcd_wrap_counter #(
  parameter int         TENS_W  = 3,
  parameter logic [7:0] MIN_BCD = 8'h00,
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic [TENS_W-1:0] tens_i,
  input  logic [3:0]        ones_i,
  output logic [TENS_W-1:0] tens_o,
  output logic [3:0]        ones_o
);

  localparam logic [TENS_W-1:0] MAX_T = TENS_W'(MAX_BCD[7:4]);
  localparam logic [3:0]        MAX_O = MAX_BCD[3:0];
  localparam logic [TENS_W-1:0] MIN_T = TENS_W'(MIN_BCD[7:4]);
  localparam logic [3:0]        MIN_O = MIN_BCD[3:0];

  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tens_o = tens_i;
    ones_o = ones_i + 4'd1;
    if ((tens_i == MAX_T) && (ones_i == MAX_O)) begin
      tens_o = MIN_T;
      ones_o = MIN_O;
    end else if (ones_i >= 4'd9) begin
      tens_o = tens_i + TENS_W'(1);
      ones_o = 4'd0;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Two-button time-setting controller for a 12-hour RTC clock. MODE walks
// RUN -> EDIT_HOUR -> EDIT_MIN -> COMMIT -> RUN, INC steps the field under
// edit. The field being edited blinks; an idle edit is abandoned after
// TIMEOUT_CYCLES. All outputs come straight from flops.
//   clk, rst_n         clock, asynchronous active-low reset
//   btn_mode, btn_inc  debounced, synchronized button levels (high = pressed)
//   bus                time_set_ctrl_if master: live time in, commit/display out
// -----------------------------------------------------------------------------
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int unsigned BLINK_CYCLES   = 12500000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_mode,
  input  logic            btn_inc,
  time_set_ctrl_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

  state_e          state_q, state_d;
  bcd_time_t       edit_q, edit_d;
  bcd_time_t       disp_q, disp_d;
  bcd_time_t       live, load_time;

  logic            mode_prev_q, mode_prev_d, inc_prev_q, inc_prev_d;
  logic            mode_arm_q, mode_arm_d, inc_arm_q, inc_arm_d;
  logic            mode_evt_q, mode_evt_d, inc_evt_q, inc_evt_d;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_off_q, blink_off_d;

  logic            set_time_q, set_time_d;
  logic            editing_q, editing_d;
  logic            blank_hour_q, blank_hour_d;
  logic            blank_min_q, blank_min_d;

  logic            hour_tens_inc;
  logic [3:0]      hour_ones_inc;
  logic [2:0]      min_tens_inc;
  logic [3:0]      min_ones_inc;
  logic            blink_restart;

  assign live = {bus.hour_10, bus.hour_1, bus.min_10, bus.min_1, bus.pm};

  bcd_wrap_counter #(
    .TENS_W (1),
    .MIN_BCD(HOUR_MIN_BCD),
    .MAX_BCD(HOUR_MAX_BCD)
  ) u_hour_cnt (
    .tens_i(edit_q.hour_10),
    .ones_i(edit_q.hour_1),
    .tens_o(hour_tens_inc),
    .ones_o(hour_ones_inc)
  );

  bcd_wrap_counter #(
    .TENS_W (3),
    .MIN_BCD(MIN_MIN_BCD),
    .MAX_BCD(MIN_MAX_BCD)
  ) u_min_cnt (
    .tens_i(edit_q.min_10),
    .ones_i(edit_q.min_1),
    .tens_o(min_tens_inc),
    .ones_o(min_ones_inc)
  );

  always_comb begin
    // Value captured on entering edit: an unset clock starts from 12:00 AM,
    // otherwise each field is taken from live time unless it is out of range.
    load_time = live;
    if (bus.need_config) begin
      load_time = DEF_TIME;
    end else begin
      if (!hour_valid(live.hour_10, live.hour_1)) begin
        load_time.hour_10 = DEF_HOUR_10;
        load_time.hour_1  = DEF_HOUR_1;
      end
      if (!min_valid(live.min_10, live.min_1)) begin
        load_time.min_10 = DEF_MIN_10;
        load_time.min_1  = DEF_MIN_1;
      end
    end

    // Rising-edge events. The arm flag stays low after reset until the button
    // has been seen released, so a press held through reset is ignored.
    mode_prev_d = btn_mode;
    inc_prev_d  = btn_inc;
    mode_arm_d  = mode_arm_q | ~btn_mode;
    inc_arm_d   = inc_arm_q | ~btn_inc;
    mode_evt_d  = btn_mode & ~mode_prev_q & mode_arm_q;
    inc_evt_d   = btn_inc & ~inc_prev_q & inc_arm_q;

    // Mode is checked first in each edit state, so a simultaneous inc is dropped.
    state_d = state_q;
    edit_d  = edit_q;
    case (state_q)
      ST_RUN: begin
        if (mode_evt_q) begin
          state_d = ST_EDIT_HOUR;
          edit_d  = load_time;
        end
      end
      ST_EDIT_HOUR: begin
        if (mode_evt_q) begin
          state_d = ST_EDIT_MIN;
        end else if (inc_evt_q) begin
          edit_d.hour_10 = hour_tens_inc;
          edit_d.hour_1  = hour_ones_inc;
          // 11 -> 12 crosses noon/midnight; 12 -> 1 keeps the half-day.
          edit_d.pm      = edit_q.pm ^ (edit_q.hour_10 && (edit_q.hour_1 == 4'd1));
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_EDIT_MIN: begin
        if (mode_evt_q) begin
          state_d = ST_COMMIT;
        end else if (inc_evt_q) begin
          edit_d.min_10 = min_tens_inc;
          edit_d.min_1  = min_ones_inc;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    // Idle counter: only runs inside edit, any button event restarts it.
    if (!is_edit(state_q) || mode_evt_q || inc_evt_q) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    // Blink restarts in the "shown" phase whenever a field is entered or
    // stepped, so the user always sees the new value immediately.
    blink_restart = (is_edit(state_d) && (state_d != state_q)) ||
                    (is_edit(state_q) && inc_evt_q);
    if (blink_restart) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == BL_LAST) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BL_W'(1);
      blink_off_d = blink_off_q;
    end

    // Outputs are derived from next-state values so they line up with state_q.
    editing_d    = is_edit(state_d);
    set_time_d   = (state_d == ST_COMMIT);
    disp_d       = editing_d ? edit_d : live;
    blank_hour_d = blink_off_d &
                   ((state_d == ST_EDIT_HOUR) || ((state_d == ST_RUN) && bus.need_config));
    blank_min_d  = blink_off_d &
                   ((state_d == ST_EDIT_MIN) || ((state_d == ST_RUN) && bus.need_config));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before this edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      edit_q       <= DEF_TIME;
      disp_q       <= DEF_TIME;
      mode_prev_q  <= 1'b0;
      inc_prev_q   <= 1'b0;
      mode_arm_q   <= 1'b0;
      inc_arm_q    <= 1'b0;
      mode_evt_q   <= 1'b0;
      inc_evt_q    <= 1'b0;
      to_cnt_q     <= '0;
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
      set_time_q   <= 1'b0;
      editing_q    <= 1'b0;
      blank_hour_q <= 1'b0;
      blank_min_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      edit_q       <= edit_d;
      disp_q       <= disp_d;
      mode_prev_q  <= mode_prev_d;
      inc_prev_q   <= inc_prev_d;
      mode_arm_q   <= mode_arm_d;
      inc_arm_q    <= inc_arm_d;
      mode_evt_q   <= mode_evt_d;
      inc_evt_q    <= inc_evt_d;
      to_cnt_q     <= to_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_off_q  <= blink_off_d;
      set_time_q   <= set_time_d;
      editing_q    <= editing_d;
      blank_hour_q <= blank_hour_d;
      blank_min_q  <= blank_min_d;
    end
  end

  assign bus.set_time     = set_time_q;
  assign bus.set_hour_10  = edit_q.hour_10;
  assign bus.set_hour_1   = edit_q.hour_1;
  assign bus.set_min_10   = edit_q.min_10;
  assign bus.set_min_1    = edit_q.min_1;
  assign bus.set_pm       = edit_q.pm;
  assign bus.disp_hour_10 = disp_q.hour_10;
  assign bus.disp_hour_1  = disp_q.hour_1;
  assign bus.disp_min_10  = disp_q.min_10;
  assign bus.disp_min_1   = disp_q.min_1;
  assign bus.disp_pm      = disp_q.pm;
  assign bus.blank_hour   = blank_hour_q;
  assign bus.blank_min    = blank_min_q;
  assign bus.editing      = editing_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed vector table for the edit flow plus hand-written sequences for the
// timing corners: midnight roll, blink phases, edit timeout, unset-clock blink
// and reset with a button held.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int TO = 100;
  localparam int BL = 8;
  localparam int NV = 21;

  typedef struct packed {
    logic       h10;
    logic [3:0] h1;
    logic [2:0] m10;
    logic [3:0] m1;
    logic       pm;
  } tm_t;

  typedef struct {
    logic m;
    logic i;
    tm_t  live;
    logic exp_editing;
    logic exp_set;
    tm_t  exp_reg;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_commit = 0;
  tm_t  last_set = '0;

  time_set_ctrl_if bus();

  time_set_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .BLINK_CYCLES  (BL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic tm_t mk(input logic h10, input logic [3:0] h1,
                             input logic [2:0] m10, input logic [3:0] m1, input logic pm);
    tm_t t;
    t.h10 = h10; t.h1 = h1; t.m10 = m10; t.m1 = m1; t.pm = pm;
    return t;
  endfunction

  function automatic tm_t get_set();
    return mk(bus.set_hour_10, bus.set_hour_1, bus.set_min_10, bus.set_min_1, bus.set_pm);
  endfunction

  function automatic tm_t get_disp();
    return mk(bus.disp_hour_10, bus.disp_hour_1, bus.disp_min_10, bus.disp_min_1, bus.disp_pm);
  endfunction

  task automatic set_live(input tm_t t);
    bus.hour_10 = t.h10;
    bus.hour_1  = t.h1;
    bus.min_10  = t.m10;
    bus.min_1   = t.m1;
    bus.pm      = t.pm;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One-cycle press; returns at the second falling edge after the press,
  // where the FSM reaction is visible on the registered outputs.
  task automatic press(input logic m, input logic i);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.set_time === 1'b1) begin
      n_commit++;
      last_set = get_set();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[NV];
  tm_t  l1, l2, l3, l4, exp_disp, t_midnight;
  int   n0, cnt;
  logic prev;

  initial begin
    l1 = mk(1'b0, 4'h9, 3'h3, 4'h0, 1'b0);   // 09:30 AM
    l2 = mk(1'b1, 4'h3, 3'h7, 4'h5, 1'b1);   // 13:75 PM, both fields invalid
    l3 = mk(1'b0, 4'hA, 3'h2, 4'hA, 1'b0);   // non-BCD nibbles
    l4 = mk(1'b0, 4'h5, 3'h5, 4'h8, 1'b0);   // 05:58 AM

    //           mode  inc   live edit  set   edit/set registers
    vecs[0]  = '{1'b1, 1'b0, l1, 1'b1, 1'b0, mk(0, 4'h9, 3'h3, 4'h0, 0)};
    vecs[1]  = '{1'b0, 1'b1, l1, 1'b1, 1'b0, mk(1, 4'h0, 3'h3, 4'h0, 0)};
    vecs[2]  = '{1'b0, 1'b1, l1, 1'b1, 1'b0, mk(1, 4'h1, 3'h3, 4'h0, 0)};
    vecs[3]  = '{1'b0, 1'b1, l1, 1'b1, 1'b0, mk(1, 4'h2, 3'h3, 4'h0, 1)};
    vecs[4]  = '{1'b0, 1'b1, l1, 1'b1, 1'b0, mk(0, 4'h1, 3'h3, 4'h0, 1)};
    vecs[5]  = '{1'b1, 1'b1, l1, 1'b1, 1'b0, mk(0, 4'h1, 3'h3, 4'h0, 1)};
    vecs[6]  = '{1'b0, 1'b1, l1, 1'b1, 1'b0, mk(0, 4'h1, 3'h3, 4'h1, 1)};
    vecs[7]  = '{1'b1, 1'b0, l1, 1'b0, 1'b1, mk(0, 4'h1, 3'h3, 4'h1, 1)};
    vecs[8]  = '{1'b1, 1'b0, l2, 1'b1, 1'b0, mk(1, 4'h2, 3'h0, 4'h0, 1)};
    vecs[9]  = '{1'b1, 1'b0, l2, 1'b1, 1'b0, mk(1, 4'h2, 3'h0, 4'h0, 1)};
    vecs[10] = '{1'b0, 1'b1, l2, 1'b1, 1'b0, mk(1, 4'h2, 3'h0, 4'h1, 1)};
    vecs[11] = '{1'b1, 1'b0, l2, 1'b0, 1'b1, mk(1, 4'h2, 3'h0, 4'h1, 1)};
    vecs[12] = '{1'b1, 1'b0, l3, 1'b1, 1'b0, mk(1, 4'h2, 3'h0, 4'h0, 0)};
    vecs[13] = '{1'b0, 1'b1, l3, 1'b1, 1'b0, mk(0, 4'h1, 3'h0, 4'h0, 0)};
    vecs[14] = '{1'b1, 1'b0, l3, 1'b1, 1'b0, mk(0, 4'h1, 3'h0, 4'h0, 0)};
    vecs[15] = '{1'b1, 1'b0, l3, 1'b0, 1'b1, mk(0, 4'h1, 3'h0, 4'h0, 0)};
    vecs[16] = '{1'b1, 1'b0, l4, 1'b1, 1'b0, mk(0, 4'h5, 3'h5, 4'h8, 0)};
    vecs[17] = '{1'b1, 1'b0, l4, 1'b1, 1'b0, mk(0, 4'h5, 3'h5, 4'h8, 0)};
    vecs[18] = '{1'b0, 1'b1, l4, 1'b1, 1'b0, mk(0, 4'h5, 3'h5, 4'h9, 0)};
    vecs[19] = '{1'b0, 1'b1, l4, 1'b1, 1'b0, mk(0, 4'h5, 3'h0, 4'h0, 0)};
    vecs[20] = '{1'b1, 1'b0, l4, 1'b0, 1'b1, mk(0, 4'h5, 3'h0, 4'h0, 0)};

    bus.new_time    = 1'b0;
    bus.need_config = 1'b0;
    bus.sec_1       = 4'd0;
    bus.sec_10      = 3'd0;
    set_live(l1);

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset editing", 32'(bus.editing), 32'd0);
    check("reset set_time", 32'(bus.set_time), 32'd0);
    check("reset blank_hour", 32'(bus.blank_hour), 32'd0);
    check("reset blank_min", 32'(bus.blank_min), 32'd0);
    check("reset set regs 12:00 AM", 32'(get_set()), 32'(mk(1, 4'h2, 3'h0, 4'h0, 0)));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table.
    n0 = n_commit;
    for (int k = 0; k < NV; k++) begin
      set_live(vecs[k].live);
      press(vecs[k].m, vecs[k].i);
      exp_disp = vecs[k].exp_editing ? vecs[k].exp_reg : vecs[k].live;
      check($sformatf("v%0d editing", k), 32'(bus.editing), 32'(vecs[k].exp_editing));
      check($sformatf("v%0d set_time", k), 32'(bus.set_time), 32'(vecs[k].exp_set));
      check($sformatf("v%0d set regs", k), 32'(get_set()), 32'(vecs[k].exp_reg));
      check($sformatf("v%0d disp", k), 32'(get_disp()), 32'(exp_disp));
    end
    repeat (2) @(negedge clk);
    check("table commit count", 32'(n_commit - n0), 32'd4);

    // 11:59 PM -> hour to 12 AM, minutes 59 -> 02 without carry, one commit.
    n0 = n_commit;
    t_midnight = mk(1, 4'h2, 3'h0, 4'h2, 0);
    set_live(mk(1, 4'h1, 3'h5, 4'h9, 1));
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("11pm inc -> 12am", 32'(get_disp()), 32'(mk(1, 4'h2, 3'h5, 4'h9, 0)));
    press(1'b1, 1'b0);
    repeat (3) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("midnight commit count", 32'(n_commit - n0), 32'd1);
    check("midnight committed value", 32'(last_set), 32'(t_midnight));

    // Blink in EDIT_HOUR, restart on inc, then idle timeout.
    set_live(l1);
    press(1'b1, 1'b0);
    cnt = 0;
    while (bus.blank_hour !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("edit blink off after BLINK_CYCLES", 32'(cnt), 32'(BL));
    check("blank_min low in EDIT_HOUR", 32'(bus.blank_min), 32'd0);
    press(1'b0, 1'b1);
    check("blink restart on inc", 32'(bus.blank_hour), 32'd0);
    n0 = n_commit;
    cnt = 0;
    while (bus.editing === 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout cycles", 32'(cnt), 32'(TO));
    @(negedge clk);
    check("timeout no set_time", 32'(n_commit - n0), 32'd0);
    check("timeout disp live", 32'(get_disp()), 32'(l1));

    // Unset clock: both fields blink in RUN, edit starts from 12:00 AM.
    bus.need_config = 1'b1;
    set_live(mk(0, 4'h7, 3'h1, 4'h5, 1));
    repeat (2) @(negedge clk);
    prev = bus.blank_hour;
    cnt = 0;
    while (bus.blank_hour === prev && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    for (int p = 0; p < 2; p++) begin
      prev = bus.blank_hour;
      cnt = 0;
      while (bus.blank_hour === prev && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      check($sformatf("run blink period %0d", p), 32'(cnt), 32'(BL));
      check($sformatf("run blink min=hour %0d", p), 32'(bus.blank_min), 32'(bus.blank_hour));
    end
    press(1'b1, 1'b0);
    check("need_config editing", 32'(bus.editing), 32'd1);
    check("need_config loads 12:00 AM", 32'(get_disp()), 32'(mk(1, 4'h2, 3'h0, 4'h0, 0)));
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    bus.need_config = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in EDIT_MIN with mode held: edit discarded, no event until re-press.
    set_live(mk(0, 4'h3, 3'h4, 4'h5, 0));
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("pre-reset edit", 32'(get_set()), 32'(mk(0, 4'h3, 3'h4, 4'h6, 0)));
    n0 = n_commit;
    @(negedge clk);
    btn_mode = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset editing", 32'(bus.editing), 32'd0);
    check("async reset set regs", 32'(get_set()), 32'(mk(1, 4'h2, 3'h0, 4'h0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("held button no event", 32'(bus.editing), 32'd0);
    check("reset no set_time", 32'(n_commit - n0), 32'd0);
    btn_mode = 1'b0;
    repeat (2) @(negedge clk);
    press(1'b1, 1'b0);
    check("re-press enters edit", 32'(bus.editing), 32'd1);
    check("re-press loads live", 32'(get_disp()), 32'(mk(0, 4'h3, 3'h4, 4'h5, 0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
